// File: rtl/speed_tick_timer_pkg.sv
// Shared speed/state encodings and the speed-to-period helper.
// Pure declarations, no logic of its own.
// Used by every speed-dependent block so they all agree on tick period.
package speed_tick_timer_pkg;

    localparam logic [1:0] SPD_NORMAL = 2'b00;
    localparam logic [1:0] SPD_INTER  = 2'b01;
    localparam logic [1:0] SPD_ADV    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Tick period in clock cycles for a speed code; reserved code 11 runs at normal speed.
    function automatic logic [31:0] period_sel(input logic [1:0] spd, input logic [31:0] base);
        logic [31:0] p;
        case (spd)
            SPD_INTER: p = base >> 1;
            SPD_ADV:   p = base >> 2;
            default:   p = base;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/speed_tick_timer_prescaler.sv
// Prescaler: counts enabled cycles and flags terminal count at period-1.
// Latency: tc is combinational from the counter register, same cycle.
// Backpressure: none; en low holds the count, clr forces it to zero.
module tick_prescaler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    assign tc = en && (cnt == (period - CNT_W'(1)));

    // Count enabled cycles, wrapping to zero on terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/speed_tick_timer.sv
// Round timer: latches speed on control, emits periodic ticks, flags time_up after ROUND_TICKS.
// Latency: first tick one period after the edge entering RUN; all outputs registered.
// Backpressure: none; optional pause input (macro SPEED_TICK_PAUSE_EN) freezes the round.
module speed_tick_timer
    import speed_tick_timer_pkg::*;
#(
    parameter logic [15:0] BASE_DIV    = 16'd50000,
    parameter logic [7:0]  ROUND_TICKS = 8'd60,
    parameter int          CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gameSpeed,
    input  logic       control,
`ifdef SPEED_TICK_PAUSE_EN
    input  logic       pause,
`endif
    output logic       tick,
    output logic [7:0] ticks_left,
    output logic       running,
    output logic       time_up
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       speed_q;
    logic [CNT_W-1:0] period;
    logic             pre_en;
    logic             pre_clr;
    logic             tc;

    // Period follows the latched speed only, so it is constant for the round.
    assign period = CNT_W'(period_sel(speed_q, 32'(BASE_DIV)));

`ifdef SPEED_TICK_PAUSE_EN
    assign pre_en = (state_q == ST_RUN) && !pause;
`else
    assign pre_en = (state_q == ST_RUN);
`endif
    // Held at zero while idle so RUN always starts a full period.
    assign pre_clr = (state_q == ST_IDLE);

    tick_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (pre_en),
        .clr    (pre_clr),
        .period (period),
        .tc     (tc)
    );

    // Next-state: start on control, finish on the tick that empties the round.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (control) state_d = ST_RUN;
            ST_RUN:  if (tc && (ticks_left == 8'd1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Speed latch: sampled once when leaving IDLE, ignored afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q <= SPD_NORMAL;
        end else if ((state_q == ST_IDLE) && control) begin
            speed_q <= gameSpeed;
        end
    end

    // Registered outputs; tc only fires in RUN so ticks_left stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick       <= 1'b0;
            ticks_left <= ROUND_TICKS;
            running    <= 1'b0;
            time_up    <= 1'b0;
        end else begin
            tick    <= tc;
            running <= (state_d == ST_RUN);
            time_up <= (state_d == ST_DONE);
            if (tc && (ticks_left != 8'd0)) begin
                ticks_left <= ticks_left - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_speed_tick_timer.sv
// Directed self-checking bench for speed_tick_timer with BASE_DIV=8, ROUND_TICKS=4.
module tb_speed_tick_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gameSpeed;
    logic       control;
`ifdef SPEED_TICK_PAUSE_EN
    logic       pause;
`endif
    logic       tick;
    logic [7:0] ticks_left;
    logic       running;
    logic       time_up;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] spd;
        int         per;
        bit         mutate;
        bit         pz;
        string      name;
    } vec_t;

    vec_t vecs[6];
    int   nvec;

    always #5 clk = ~clk;

    speed_tick_timer #(
        .BASE_DIV    (16'd8),
        .ROUND_TICKS (8'd4),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gameSpeed  (gameSpeed),
        .control    (control),
`ifdef SPEED_TICK_PAUSE_EN
        .pause      (pause),
`endif
        .tick       (tick),
        .ticks_left (ticks_left),
        .running    (running),
        .time_up    (time_up)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " tick"},       32'(tick),       32'd0);
        chk({tag, " ticks_left"}, 32'(ticks_left), 32'd4);
        chk({tag, " running"},    32'(running),    32'd0);
        chk({tag, " time_up"},    32'(time_up),    32'd0);
    endtask

    // Mid-cycle async reset, checked before any clock edge, then released.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        control = 1'b0;
        #1 chk_reset_vals(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_round(input vec_t v);
        int last;
        int nt;
        int exp_sp;
        last = 0;
        nt   = 0;
        @(negedge clk);
        gameSpeed = v.spd;
        control   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4 * v.per + 60; k++) begin
            @(negedge clk);
            if (k == 0) chk({v.name, " running at start"}, 32'(running), 32'd1);
`ifdef SPEED_TICK_PAUSE_EN
            if (pause) begin
                chk({v.name, " no tick while paused"}, 32'(tick), 32'd0);
                chk({v.name, " ticks_left frozen"}, 32'(ticks_left), 32'd3);
                chk({v.name, " running while paused"}, 32'(running), 32'd1);
            end
`endif
            if (tick) begin
                nt++;
                exp_sp = (v.pz && nt == 2) ? v.per + 10 : v.per;
                if (nt <= 4) begin
                    chk({v.name, " tick spacing"}, 32'(k - last), 32'(exp_sp));
                    chk({v.name, " ticks_left"}, 32'(ticks_left), 32'(4 - nt));
                    chk({v.name, " running"}, 32'(running), (nt == 4) ? 32'd0 : 32'd1);
                    chk({v.name, " time_up"}, 32'(time_up), (nt == 4) ? 32'd1 : 32'd0);
                end
                last = k;
            end
            if (v.mutate && k == 3) begin
                gameSpeed = 2'b00;
                control   = 1'b0;
            end
`ifdef SPEED_TICK_PAUSE_EN
            if (v.pz && nt == 1 && k == last + 3)  pause = 1'b1;
            if (v.pz && nt == 1 && k == last + 13) pause = 1'b0;
`endif
        end
        chk({v.name, " tick count"}, 32'(nt), 32'd4);
        chk({v.name, " final time_up"}, 32'(time_up), 32'd1);
        chk({v.name, " final running"}, 32'(running), 32'd0);
        chk({v.name, " final ticks_left"}, 32'(ticks_left), 32'd0);
    endtask

    initial begin
        vecs[0] = '{spd: 2'b00, per: 8, mutate: 1'b0, pz: 1'b0, name: "normal"};
        vecs[1] = '{spd: 2'b01, per: 4, mutate: 1'b0, pz: 1'b0, name: "inter"};
        vecs[2] = '{spd: 2'b10, per: 2, mutate: 1'b0, pz: 1'b0, name: "adv"};
        vecs[3] = '{spd: 2'b11, per: 8, mutate: 1'b0, pz: 1'b0, name: "reserved"};
        vecs[4] = '{spd: 2'b10, per: 2, mutate: 1'b1, pz: 1'b0, name: "latch"};
        nvec = 5;
`ifdef SPEED_TICK_PAUSE_EN
        vecs[5] = '{spd: 2'b00, per: 8, mutate: 1'b0, pz: 1'b1, name: "pause"};
        nvec = 6;
        pause = 1'b0;
`endif

        rst       = 1'b0;
        control   = 1'b0;
        gameSpeed = 2'b00;

        // Reset takes effect before the first clock edge.
        #2 rst = 1'b1;
        #1 chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;

        // Idle with control low: nothing moves.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k % 5 == 4) chk_reset_vals("idle");
        end

        for (int i = 0; i < nvec; i++) begin
            do_reset({vecs[i].name, " reset"});
            run_round(vecs[i]);
        end

        // Reset after the second tick, with a tick pulse still on the output.
        begin
            int nt;
            nt = 0;
            do_reset("midround pre");
            @(negedge clk);
            gameSpeed = 2'b00;
            control   = 1'b1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (tick) nt++;
                if (nt == 2) break;
            end
            chk("midround two ticks seen", 32'(nt), 32'd2);
            chk("midround ticks_left before rst", 32'(ticks_left), 32'd2);
            #2 rst = 1'b1;
            #1 chk_reset_vals("midround rst");
            control = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            run_round(vecs[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
